prog_clk_divider: RTL and testbench
===================================

Name: prog_clk_divider

Overview:
Programmable clock divider and tick generator, the parametrised successor to the fixed power-of-two divider that drives the 1 Hz output.
- Divides sysclk by any runtime-loaded integer N.
- Provides a one-cycle tick strobe and a near-50% square wave.
- Supports continuous and one-shot modes.
- Divisor changes are deferred to the period boundary so the outputs never glitch.
- Sits between the board clock and timing consumers: display refresh, debouncers, seconds counters.

Parameters:
WIDTH, 27, width of divisor and period counter.
DEFAULT_DIV, 100_000_000, divisor after reset (1 Hz at 100 MHz); must satisfy 1 <= DEFAULT_DIV < 2**WIDTH.

Ports:
sysclk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
enable  in  1  1 = counter advances; 0 = freeze (hold, not clear).
clear  in  1  synchronous: go to IDLE, cnt=0; divisor registers kept.
oneshot  in  1  mode select, latched on IDLE->RUN.
start  in  1  one-shot trigger pulse.
div_in  in  WIDTH  new divisor N.
div_load  in  1  one-cycle strobe qualifying div_in.
tick  out  1  one-cycle strobe at end of each period.
sq_out  out  1  square wave, period N.
done  out  1  sticky: one-shot period completed.
busy  out  1  state == RUN.
div_pending  out  1  a deferred divisor is waiting.
div_cur  out  WIDTH  divisor in effect.
count  out  WIDTH  current cnt.

Behaviour:
Reset values (next edge with reset=1):
- state=IDLE, cnt=0, div_cur=DEFAULT_DIV, div_pend=0, div_pending=0, done=0, mode_r=0.
- Therefore tick=0 and sq_out=0.
- reset has priority over every other input, including mid-period and mid-load.

Priority below reset: clear > FSM/count > load.
- clear also drops div_pending, discarding the pending value.

Sanitising: div_in==0 is treated as 1 everywhere.

FSM IDLE:
- cnt held at 0; tick=0; sq_out=0.
- Transitions to RUN when enable && (!oneshot || start).
- mode_r <= oneshot on that transition.
- done <= 0 on that transition.
- The first RUN cycle has cnt=0.

FSM RUN:
- If enable: cnt <= (cnt==div_cur-1) ? 0 : cnt+1.
- If !enable: all state holds.
- wrap = enable && cnt==div_cur-1.
- At wrap with mode_r=1: next state IDLE, done <= 1.
- At wrap with mode_r=0: stay in RUN; return to IDLE only via clear or reset.

Outputs, combinational from registers:
- tick = busy && wrap.
- sq_out = busy && (cnt < div_cur>>1), i.e. high for floor(N/2) cycles, then low for ceil(N/2).
- N=1: tick every enabled cycle; sq_out stays 0.

Divisor load:
- div_load in IDLE: div_cur <= div_in next edge.
- div_load in RUN without wrap: div_pend <= div_in, div_pending <= 1.
- A further load while pending overwrites div_pend; the last load wins.
- At wrap with div_pending=1: div_cur <= div_pend, div_pending <= 0.
- div_load coincident with wrap: div_cur <= div_in directly, div_pending <= 0, any older pending value is discarded.
- Latency: a new N governs the period that starts immediately after the wrap.

Counter invariant: cnt < div_cur at all times.
- This holds because div_cur changes only in IDLE (cnt=0) or at wrap (cnt becomes 0).
- Counter arithmetic is unsigned WIDTH-bit and never overflows.

Decomposition:
Shared package (div_pkg):
- state enum {IDLE, RUN}.
- Default WIDTH/DEFAULT_DIV constants for the board clock (100 MHz).

Sub-module mod_n_counter:
- Ports: sysclk, reset, en, clr, modulus, cnt, wrap.
- Holds the modulo-N count logic.
- The top level keeps the FSM, mode latch, divisor staging and output decode.

Test Plan:
1. DEFAULT_DIV=4; reset, then enable=1, oneshot=0 -> busy next cycle; cnt 0,1,2,3,0; tick high when cnt=3 every 4 cycles; sq_out 1,1,0,0 repeating.
2. Load 5 in IDLE, then run continuous -> div_cur=5; tick period 5; sq_out high 2 cycles, low 3 cycles.
3. Load 3, oneshot=1, start pulse -> exactly one tick on the 3rd RUN cycle; then busy=0, done=1, no further ticks; next start clears done.
4. N=4 running, div_load=6 at cnt=1 -> div_pending=1, period finishes at cnt=3 with tick; div_cur=6, pending=0; next tick after 6 cycles. Load coincident with wrap -> applied immediately, pending stays 0.
5. enable=0 at cnt=2 for 3 cycles -> cnt frozen at 2, no tick; resumes 3 then tick. div_in=0 loaded -> div_cur=1, tick every enabled cycle, sq_out=0.
6. reset (or clear) asserted at cnt=2 with pending load -> next edge: IDLE, cnt=0, tick=0, sq_out=0, div_pending=0; div_cur=DEFAULT_DIV after reset, unchanged after clear.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and board-clock defaults for the programmable clock divider.
package div_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int DEF_WIDTH = 27;
    localparam int DEF_DIV   = 100_000_000;

endpackage

// File: rtl/mod_n_counter.sv
// Modulo-N period counter: counts 0..modulus-1 while enabled, flags the last cycle.
module mod_n_counter #(
    parameter int WIDTH = 27
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    // modulus is never 0 (sanitised upstream), so modulus-1 cannot underflow
    assign wrap = en && (cnt_q == modulus - WIDTH'(1));
    assign cnt  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = wrap ? '0 : cnt_q + WIDTH'(1);
    end

    always_ff @(posedge sysclk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/prog_clk_divider.sv
// Programmable clock divider: tick strobe and square wave of period N, with
// continuous/one-shot modes and divisor changes deferred to the period boundary.
module prog_clk_divider
    import div_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DEFAULT_DIV = DEF_DIV
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             oneshot,
    input  logic             start,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic             tick,
    output logic             sq_out,
    output logic             done,
    output logic             busy,
    output logic             div_pending,
    output logic [WIDTH-1:0] div_cur,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(DEFAULT_DIV);

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic             pending_q, pending_d;
    logic [WIDTH-1:0] div_cur_q, div_cur_d;
    logic [WIDTH-1:0] div_pend_q, div_pend_d;
    logic [WIDTH-1:0] div_in_s;
    logic [WIDTH-1:0] cnt;
    logic             wrap;

    assign busy     = (state_q == RUN);
    assign div_in_s = (div_in == '0) ? WIDTH'(1) : div_in;

    mod_n_counter #(.WIDTH(WIDTH)) u_cnt (
        .sysclk  (sysclk),
        .reset   (reset),
        .en      (busy && enable),
        .clr     (clear),
        .modulus (div_cur_q),
        .cnt     (cnt),
        .wrap    (wrap)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        done_d     = done_q;
        pending_d  = pending_q;
        div_cur_d  = div_cur_q;
        div_pend_d = div_pend_q;
        if (clear) begin
            state_d   = IDLE;
            pending_d = 1'b0;
        end else if (state_q == IDLE) begin
            if (div_load)
                div_cur_d = div_in_s;
            if (enable && (!oneshot || start)) begin
                state_d = RUN;
                mode_d  = oneshot;
                done_d  = 1'b0;
            end
        end else if (wrap) begin
            if (mode_q) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            // a load landing on the wrap supersedes any older staged value
            if (div_load)
                div_cur_d = div_in_s;
            else if (pending_q)
                div_cur_d = div_pend_q;
            pending_d = 1'b0;
        end else if (div_load) begin
            div_pend_d = div_in_s;
            pending_d  = 1'b1;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            done_q     <= 1'b0;
            pending_q  <= 1'b0;
            div_cur_q  <= RESET_DIV;
            div_pend_q <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            done_q     <= done_d;
            pending_q  <= pending_d;
            div_cur_q  <= div_cur_d;
            div_pend_q <= div_pend_d;
        end
    end

    assign tick        = busy && wrap;
    assign sq_out      = busy && (cnt < (div_cur_q >> 1));
    assign done        = done_q;
    assign div_pending = pending_q;
    assign div_cur     = div_cur_q;
    assign count       = cnt;

endmodule

// File: tb/tb_prog_clk_divider.sv
// Bench for prog_clk_divider: directed literal checks plus randomized run against an integer model.
module tb_prog_clk_divider;

    localparam int W  = 8;
    localparam int DD = 4;

    logic         sysclk = 1'b0;
    logic         reset = 1'b1, enable = 1'b0, clear = 1'b0, oneshot = 1'b0, start = 1'b0;
    logic [W-1:0] div_in = '0;
    logic         div_load = 1'b0;
    logic         tick, sq_out, done, busy, div_pending;
    logic [W-1:0] div_cur, count;

    int n_cmp = 0, n_bad = 0;

    // model state: plain integers describing the period in progress
    bit m_run, m_mode, m_done, m_haspend;
    int m_phase, m_period, m_next;

    prog_clk_divider #(.WIDTH(W), .DEFAULT_DIV(DD)) dut (
        .sysclk(sysclk), .reset(reset), .enable(enable), .clear(clear),
        .oneshot(oneshot), .start(start), .div_in(div_in), .div_load(div_load),
        .tick(tick), .sq_out(sq_out), .done(done), .busy(busy),
        .div_pending(div_pending), .div_cur(div_cur), .count(count)
    );

    always #5 sysclk = ~sysclk;

    function automatic int san(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bool_last: begin
            bit last;
            if (reset) begin
                m_run = 0; m_mode = 0; m_done = 0; m_haspend = 0;
                m_phase = 0; m_period = DD;
            end else if (clear) begin
                m_run = 0; m_phase = 0; m_haspend = 0;
            end else if (!m_run) begin
                if (div_load) m_period = san(int'(div_in));
                if (enable && (!oneshot || start)) begin
                    m_run = 1; m_mode = oneshot; m_done = 0; m_phase = 0;
                end
            end else if (enable) begin
                last    = (m_phase == m_period - 1);
                m_phase = (m_phase + 1) % m_period;
                if (last) begin
                    if (m_mode) begin m_run = 0; m_done = 1; end
                    if (div_load) m_period = san(int'(div_in));
                    else if (m_haspend) m_period = m_next;
                    m_haspend = 0;
                end else if (div_load) begin
                    m_next = san(int'(div_in)); m_haspend = 1;
                end
            end else if (div_load) begin
                m_next = san(int'(div_in)); m_haspend = 1;
            end
        end
    endtask

    task automatic check_model();
        int exp_tick;
        exp_tick = (m_run && enable && m_phase == m_period - 1) ? 1 : 0;
        chk("tick",        int'(tick),        exp_tick);
        chk("sq_out",      int'(sq_out),      (m_run && m_phase < m_period / 2) ? 1 : 0);
        chk("busy",        int'(busy),        int'(m_run));
        chk("done",        int'(done),        int'(m_done));
        chk("div_pending", int'(div_pending), int'(m_haspend));
        chk("div_cur",     int'(div_cur),     m_period);
        chk("count",       int'(count),       m_phase);
    endtask

    // one clock: inputs already set; model advances on the edge, compare on the falling edge
    task automatic cycle();
        @(posedge sysclk);
        model_step();
        @(negedge sysclk);
        check_model();
    endtask

    task automatic idle_inputs();
        reset = 0; clear = 0; enable = 0; oneshot = 0; start = 0; div_load = 0; div_in = '0;
    endtask

    initial begin
        int ticks;
        m_period = DD;
        // reset state
        reset = 1;
        cycle();
        chk("rst_busy", int'(busy), 0);
        chk("rst_div_cur", int'(div_cur), 4);
        chk("rst_sq", int'(sq_out), 0);

        // continuous with default N=4
        idle_inputs(); enable = 1;
        cycle();
        for (int i = 0; i < 8; i++) begin
            chk("t1_count", int'(count), i % 4);
            chk("t1_tick", int'(tick), (i % 4 == 3) ? 1 : 0);
            chk("t1_sq", int'(sq_out), (i % 4 < 2) ? 1 : 0);
            cycle();
        end

        // load 5 in IDLE then run
        idle_inputs(); clear = 1; cycle();
        idle_inputs(); div_load = 1; div_in = 8'd5; cycle();
        chk("t2_div_cur", int'(div_cur), 5);
        idle_inputs(); enable = 1; cycle();
        for (int i = 0; i < 10; i++) begin
            chk("t2_tick", int'(tick), (i % 5 == 4) ? 1 : 0);
            chk("t2_sq", int'(sq_out), (i % 5 < 2) ? 1 : 0);
            cycle();
        end

        // one-shot N=3
        idle_inputs(); clear = 1; cycle();
        idle_inputs(); enable = 1; oneshot = 1; div_load = 1; div_in = 8'd3; cycle();
        chk("t3_wait_busy", int'(busy), 0);
        div_load = 0; start = 1; cycle();
        start = 0;
        ticks = 0;
        for (int i = 0; i < 6; i++) begin
            ticks += int'(tick);
            cycle();
        end
        chk("t3_ticks", ticks, 1);
        chk("t3_done", int'(done), 1);
        chk("t3_busy", int'(busy), 0);
        start = 1; cycle();
        chk("t3_done_clr", int'(done), 0);

        // divisor 0 is treated as 1
        idle_inputs(); clear = 1; cycle();
        idle_inputs(); div_load = 1; div_in = 8'd0; cycle();
        chk("t5_div_cur", int'(div_cur), 1);
        idle_inputs(); enable = 1; cycle();
        for (int i = 0; i < 3; i++) begin
            chk("t5_tick", int'(tick), 1);
            chk("t5_sq", int'(sq_out), 0);
            cycle();
        end

        // pending load discarded by reset
        enable = 0; div_load = 1; div_in = 8'd7; cycle();
        chk("t6_pending", int'(div_pending), 1);
        div_load = 0; reset = 1; cycle();
        chk("t6_pending_rst", int'(div_pending), 0);
        chk("t6_div_cur_rst", int'(div_cur), 4);

        // randomized stimulus against the model
        idle_inputs();
        for (int i = 0; i < 4000; i++) begin
            reset    = ($urandom_range(0, 299) == 0);
            clear    = ($urandom_range(0, 149) == 0);
            enable   = ($urandom_range(0, 99) < 85);
            if ($urandom_range(0, 39) == 0) oneshot = ~oneshot;
            start    = ($urandom_range(0, 9) == 0);
            div_load = ($urandom_range(0, 9) == 0);
            div_in   = W'($urandom_range(0, 7));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
